// File: rtl/fetch_redirect_ctrl.sv
// IF-stage sequencer: owns the PC, drives the imem request/ack handshake,
// loads IF/ID, applies ID-stage redirects and counts redirects/stall cycles.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc1,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             id_stall,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned XLEN = 32;

  // RST: idle cycle after reset; FETCH: request outstanding at pc;
  // DRAIN: wrong-path request still in flight; BUF: IF/ID and skid both full
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_BUF   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc1_q, skid_pc1_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]   ifid_pc1_q, ifid_pc1_d;
  logic              req_q, req_d;
  logic [CNT_W-1:0]  redir_q, redir_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              take_c;
  logic [XLEN-1:0]   pc_inc_c;

  // PC is only updated on ack/redirect, so it is also the held DRAIN address
  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign ifid_valid   = ifid_valid_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc1     = ifid_pc1_q;
  assign redirect_cnt = redir_q;
  assign stall_cnt    = stall_q;

  // Next-state, datapath and counter update; a stalled ID never redirects
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_instr_d = skid_instr_q;
    skid_pc1_d   = skid_pc1_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc1_d   = ifid_pc1_q;
    req_d        = 1'b0;
    redir_d      = redir_q;
    stall_d      = stall_q + CNT_W'(ifid_valid_q & id_stall);
    take_c       = ifid_valid_q & br_taken & ~id_stall;
    pc_inc_c     = pc_q + 32'd1;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (take_c) begin
          redir_d      = redir_q + CNT_W'(1);
          ifid_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = br_target;
          end else begin
            pend_d  = br_target;
            state_d = ST_DRAIN;
          end
        end else if (id_stall) begin
          if (imem_ack) begin
            skid_instr_d = imem_rdata;
            skid_pc1_d   = pc_inc_c;
            pc_d         = pc_inc_c;
            state_d      = ST_BUF;
          end
        end else if (imem_ack) begin
          ifid_instr_d = imem_rdata;
          ifid_pc1_d   = pc_inc_c;
          ifid_valid_d = 1'b1;
          pc_d         = pc_inc_c;
        end else begin
          ifid_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        ifid_valid_d = 1'b0;
        if (imem_ack) begin
          pc_d    = pend_q;
          state_d = ST_FETCH;
        end
      end
      ST_BUF: begin
        if (id_stall) begin
          state_d = ST_BUF;
        end else if (take_c) begin
          redir_d      = redir_q + CNT_W'(1);
          ifid_valid_d = 1'b0;
          pc_d         = br_target;
          state_d      = ST_FETCH;
        end else begin
          ifid_instr_d = skid_instr_q;
          ifid_pc1_d   = skid_pc1_q;
          ifid_valid_d = 1'b1;
          state_d      = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      skid_instr_q <= '0;
      skid_pc1_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc1_q   <= '0;
      req_q        <= 1'b0;
      redir_q      <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pc1_q   <= skid_pc1_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc1_q   <= ifid_pc1_d;
      req_q        <= req_d;
      redir_q      <= redir_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: program-order scoreboard plus directed
// checks of throughput, redirect, stall/skid and reset-while-draining.
module tb_fetch_redirect_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             ifid_valid;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc1;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             id_stall;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_acc    = 0;
  int unsigned lat_min, lat_max, cur_lat, wait_cnt, p_stall, p_take;
  int unsigned exp_redir, exp_stall;
  bit          force_stall, force_take;
  logic [31:0] force_target;
  logic [31:0] model_pc;
  logic [31:0] exp_q[$];
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;

  fetch_redirect_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1),
    .br_taken(br_taken), .br_target(br_target), .id_stall(id_stall),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ {a[15:0], a[31:16]};
  endfunction

  function automatic int unsigned pick_lat();
    return $urandom_range(lat_max, lat_min);
  endfunction

  // Mostly small targets, sometimes right below the 32-bit wrap point
  function automatic logic [31:0] rand_target();
    if ($urandom_range(7, 0) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
    return 32'($urandom_range(255, 0));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(imem_req),     32'd0);
    check({tag, "_addr"},  imem_addr,         RESET_PC);
    check({tag, "_valid"}, 32'(ifid_valid),   32'd0);
    check({tag, "_instr"}, ifid_instr,        32'd0);
    check({tag, "_pc1"},   ifid_pc1,          32'd0);
    check({tag, "_rcnt"},  32'(redirect_cnt), 32'd0);
    check({tag, "_scnt"},  32'(stall_cnt),    32'd0);
  endtask

  task automatic do_reset(input bit chk);
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    br_taken = 1'b0; br_target = '0; id_stall = 1'b0;
    wait_cnt = 0; cur_lat = pick_lat();
    exp_q.delete();
    model_pc = RESET_PC;
    exp_q.push_back(model_pc);
    repeat (2) @(negedge clk);
    if (chk) check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  // One cycle of memory model and ID-side stimulus; every instruction that ID
  // accepts determines the next program-order PC, which is queued as expected
  task automatic drive_cycle();
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (wait_cnt >= cur_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = 0;
        cur_lat    = pick_lat();
      end else begin
        wait_cnt++;
      end
    end
    id_stall  = force_stall || ($urandom_range(99, 0) < p_stall);
    br_taken  = force_take  || ($urandom_range(99, 0) < p_take);
    br_target = force_take ? force_target : rand_target();
    if (ifid_valid && !id_stall) begin
      model_pc = br_taken ? br_target : model_pc + 32'd1;
      exp_q.push_back(model_pc);
    end
  endtask

  // Monitor: pops one expected instruction per ID acceptance, tracks counters
  // and the request-hold rule
  initial begin : monitor
    logic [31:0]      e;
    logic [CNT_W-1:0] er, es;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_redir = 0; exp_stall = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
      end else begin
        if (prev_req && !prev_ack) begin
          check("req_held", 32'(imem_req), 32'd1);
          check("addr_stable", imem_addr, prev_addr);
        end
        er = CNT_W'(exp_redir);
        es = CNT_W'(exp_stall);
        check("redirect_cnt", 32'(redirect_cnt), 32'(er));
        check("stall_cnt", 32'(stall_cnt), 32'(es));
        if (ifid_valid && !id_stall) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got pc1 %h, required no delivery", ifid_pc1);
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc1", ifid_pc1, e + 32'd1);
            check("ifid_instr", ifid_instr, mem_word(e));
          end
          if (br_taken) exp_redir++;
        end
        if (ifid_valid && id_stall) exp_stall++;
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    force_stall = 1'b0; force_take = 1'b0; force_target = '0;
    lat_min = 0; lat_max = 0; p_stall = 0; p_take = 0;
    do_reset(1'b1);

    // Zero-wait streaming from RESET_PC
    drive_cycle();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    for (int k = 1; k <= 4; k++) begin
      drive_cycle();
      check("stream_valid", 32'(ifid_valid), 32'd1);
      check("stream_pc1", ifid_pc1, RESET_PC + 32'(k));
    end

    // Taken branch at pc 4 with same-cycle ack: one bubble
    force_take = 1'b1; force_target = 32'h20;
    drive_cycle();
    check("br_pc1", ifid_pc1, 32'd5);
    force_take = 1'b0;
    drive_cycle();
    check("br_bubble", 32'(ifid_valid), 32'd0);
    check("br_addr", imem_addr, 32'h20);
    check("br_rcnt", 32'(redirect_cnt), 32'd1);
    drive_cycle();
    check("br_tgt_valid", 32'(ifid_valid), 32'd1);
    check("br_tgt_pc1", ifid_pc1, 32'h21);

    // Four stall cycles: IF/ID holds, skid fills, no request while buffered
    force_stall = 1'b1;
    drive_cycle();
    check("stall_pc1", ifid_pc1, 32'h22);
    for (int k = 0; k < 3; k++) begin
      drive_cycle();
      check("buf_req", 32'(imem_req), 32'd0);
      check("buf_hold_pc1", ifid_pc1, 32'h22);
    end
    force_stall = 1'b0;
    drive_cycle();
    check("stall_end_pc1", ifid_pc1, 32'h22);
    check("stall_cnt4", 32'(stall_cnt), 32'd4);
    drive_cycle();
    check("skid_pc1", ifid_pc1, 32'h23);
    drive_cycle();
    check("after_skid_pc1", ifid_pc1, 32'h24);

    // Randomized latency, stalls and branches
    lat_max = 3; p_stall = 30; p_take = 20;
    repeat (3000) drive_cycle();

    // Redirect while a 3-cycle fetch is outstanding, then reset mid-drain
    lat_min = 3; lat_max = 3; p_stall = 0; p_take = 0;
    do_reset(1'b0);
    force_take = 1'b1; force_target = 32'h40;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      if (ifid_valid) break;
    end
    force_take = 1'b0;
    check("drain_setup_valid", 32'(ifid_valid), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive_cycle();
      check("drain_req", 32'(imem_req), 32'd1);
      check("drain_addr", imem_addr, RESET_PC + 32'd1);
      check("drain_valid", 32'(ifid_valid), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    do_reset(1'b0);
    drive_cycle();
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, RESET_PC);

    // Settle with zero-wait memory and confirm nothing is left unaccounted
    lat_min = 0; lat_max = 0;
    repeat (20) drive_cycle();
    @(negedge clk); #1;
    check("final_valid", 32'(ifid_valid), 32'd1);
    check("final_queue", 32'(exp_q.size()), 32'd1);
    check("accepted_enough", 32'(n_acc > 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
